// File: rtl/md_unit_pkg.sv
// Shared pipeline definitions for the multiply/divide unit:
// mdop and hlsel encodings, default latencies, FSM state type.
package md_unit_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;

   localparam logic HL_LO = 1'b0;
   localparam logic HL_HI = 1'b1;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_t;

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
// Ports: mdop, a, b in; res {hi,lo}, valid, div_op, dzero out.
module md_calc
   import md_unit_pkg::*;
(
   input  logic [2:0]  mdop,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] res,
   output logic        valid,
   output logic        div_op,
   output logic        dzero
);

   logic signed [63:0] a_sx;
   logic signed [63:0] b_sx;
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] b_nz;
   logic signed [31:0] q_s;
   logic signed [31:0] r_s;
   logic        [31:0] q_u;
   logic        [31:0] r_u;
   logic               b_zero;
   logic               ovf;

   assign a_sx   = $signed({{32{a[31]}}, a});
   assign b_sx   = $signed({{32{b[31]}}, b});
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'b0, a} * {32'b0, b};

   // Divisor forced to 1 on zero so the dividers never see /0;
   // the result is discarded at commit anyway.
   assign b_zero = (b == 32'd0);
   assign b_nz   = b_zero ? 32'd1 : b;

   // -2^31 / -1 overflows 32 bits; pin it to the wrapped value.
   assign ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   assign q_s = ovf ? 32'sh8000_0000 : $signed(a) / $signed(b_nz);
   assign r_s = ovf ? 32'sd0 : $signed(a) % $signed(b_nz);
   assign q_u = a / b_nz;
   assign r_u = a % b_nz;

   always_comb begin
      res    = 64'd0;
      valid  = 1'b1;
      div_op = 1'b0;
      case (mdop)
         MD_MULT:  res = prod_s;
         MD_MULTU: res = prod_u;
         MD_DIV: begin
            res    = {r_s, q_s};
            div_op = 1'b1;
         end
         MD_DIVU: begin
            res    = {r_u, q_u};
            div_op = 1'b1;
         end
         default: valid = 1'b0;
      endcase
   end

   assign dzero = div_op & b_zero;

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning HI/LO with timed latency.
// Ports: clk, reset, a, b, mdop, mdstart, hlwrite, hlsel, hlread in;
//        hl_rdata, busy, md_hazard out.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  mdop,
   input  logic        mdstart,
   input  logic        hlwrite,
   input  logic        hlsel,
   input  logic        hlread,
   output logic [31:0] hl_rdata,
   output logic        busy,
   output logic        md_hazard
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES
                                                    : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

   md_state_t     state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [31:0]   p_hi, p_hi_n;
   logic [31:0]   p_lo, p_lo_n;
   logic          p_dz, p_dz_n;
   logic [31:0]   hi, hi_n;
   logic [31:0]   lo, lo_n;

   logic [63:0]   res;
   logic          op_valid;
   logic          div_op;
   logic          dzero;

   md_calc u_calc (
      .mdop   (mdop),
      .a      (a),
      .b      (b),
      .res    (res),
      .valid  (op_valid),
      .div_op (div_op),
      .dzero  (dzero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MD_IDLE;
         cnt   <= '0;
         p_hi  <= '0;
         p_lo  <= '0;
         p_dz  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         p_hi  <= p_hi_n;
         p_lo  <= p_lo_n;
         p_dz  <= p_dz_n;
         hi    <= hi_n;
         lo    <= lo_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      p_hi_n  = p_hi;
      p_lo_n  = p_lo;
      p_dz_n  = p_dz;
      hi_n    = hi;
      lo_n    = lo;
      case (state)
         MD_IDLE: begin
            if (mdstart && op_valid) begin
               state_n          = MD_RUN;
               cnt_n            = div_op ? DIV_LD : MULT_LD;
               {p_hi_n, p_lo_n} = res;
               p_dz_n           = dzero;
            end else if (!mdstart && hlwrite) begin
               // any mdstart, even a reserved one, blocks mthi/mtlo
               if (hlsel == HL_HI) hi_n = a;
               else                lo_n = a;
            end
         end
         MD_RUN: begin
            if (cnt == '0) begin
               state_n = MD_IDLE;
               if (!p_dz) begin
                  hi_n = p_hi;
                  lo_n = p_lo;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: state_n = MD_IDLE;
      endcase
   end

   assign busy      = (state == MD_RUN);
   assign md_hazard = mdstart | busy;
   assign hl_rdata  = !hlread ? 32'd0 :
                      (hlsel == HL_HI) ? hi : lo;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the execute stage of the five-stage MIPS pipeline. It consumes the `mdop`/`mdstart`/`hlsel`/`hlwrite`/`hlread` controls and the forwarded operands registered by the decode/execute pipeline register. It owns the HI/LO registers and models multi-cycle mult/div latency with a busy counter. It also exports the busy indication that the hazard unit uses to stall HI/LO-dependent instructions in decode.

## Interface
- `MULT_CYCLES`, default 5: busy duration for mult/multu.
- `DIV_CYCLES`, default 10: busy duration for div/divu.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `a`  in  32  forwarded rs operand.
- `b`  in  32  forwarded rt operand.
- `mdop`  in  3  operation: 0 mult, 1 multu, 2 div, 3 divu, others reserved (no-op).
- `mdstart`  in  1  start request for `mdop`.
- `hlwrite`  in  1  mthi/mtlo write request.
- `hlsel`  in  1  target/source select: 0 = LO, 1 = HI.
- `hlread`  in  1  mfhi/mflo read.
- `hl_rdata`  out  32  selected HI/LO value, or 0 when `hlread`=0.
- `busy`  out  1  registered; high while an operation is in flight.
- `md_hazard`  out  1  combinational `mdstart | busy`; consumed by the hazard unit.

## Operation
- State is IDLE or RUN, encoded as `busy`. The unit also holds a countdown counter `cnt`, pending registers `p_hi`/`p_lo`, `hi` and `lo`.
- **Start (IDLE):** `mdstart`=1 with a valid `mdop`:
  - latches the full result into `p_hi`/`p_lo` from `a`/`b` in that cycle;
  - loads `cnt` with N−1, where N is `MULT_CYCLES` or `DIV_CYCLES`;
  - sets `busy`.
- **Result rules:**
  - mult: signed 64-bit product, `{p_hi,p_lo}`.
  - multu: unsigned 64-bit product, `{p_hi,p_lo}`.
  - div: `p_lo` = signed quotient truncated toward zero; `p_hi` = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- **Divide by zero:** accepted and timed normally, but the commit leaves `hi`/`lo` unchanged.
- **RUN:**
  - `cnt` decrements each cycle.
  - In the cycle where `cnt`==0: commit `hi`←`p_hi`, `lo`←`p_lo`, clear `busy`.
- **hlwrite:**
  - While IDLE with no `mdstart`: writes `a` to HI (`hlsel`=1) or LO (`hlsel`=0) at the clock edge.
  - While `busy`: ignored.
- **Simultaneous events:**
  - `mdstart` and `hlwrite` in the same cycle: `mdstart` wins.
  - `mdstart` while `busy`: ignored; the hazard unit guarantees this never occurs.
  - Reserved `mdop` with `mdstart`: no effect.
- **hl_rdata:** combinational from the current `hi`/`lo`. During `busy` it returns the pre-operation values; the stall is the hazard unit's responsibility.
- **Reset:** `hi`, `lo`, `p_hi`, `p_lo`, `cnt` ← 0 and `busy` ← 0, including mid-operation (the in-flight result is discarded).

## Timing
- `mdstart` is sampled in cycle T: `busy`=1 from T+1 through T+N.
- `hi`/`lo` update at the edge ending T+N and are visible via `hl_rdata` in T+N+1.
- A new `mdstart` is accepted in T+N+1 at the earliest.
- `md_hazard` is high in T (combinational) and through T+N.
- `hlwrite` in cycle T updates the register at the edge ending T; the value is readable in T+1.
- There is no internal HI/LO bypass.

## Structure
- Shared pipeline package holds:
  - the `mdop` encodings `MD_MULT`/`MD_MULTU`/`MD_DIV`/`MD_DIVU`;
  - the `hlsel` encodings `HL_LO`/`HL_HI`;
  - the default cycle counts.
- One sub-module, `md_calc`: combinational 64-bit result generation from `mdop`, `a`, `b`, including the divide-by-zero flag.
- Counter, HI/LO registers and control stay in `md_unit`.

## Test plan
- **mult:** `a`=0xFFFFFFFE (−2), `b`=3, `mdstart` → `busy` for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. mfhi/mflo read correctly at T+6.
- **multu:** same operands → HI=0x00000002, LO=0xFFFFFFFA. **divu:** 7/2 → LO=3, HI=1, with `busy` exactly 10 cycles.
- **div:** −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. **div by zero:** `b`=0 with prior HI=0x11, LO=0x22 → `busy` for 10 cycles, HI/LO unchanged.
- **mthi/mtlo:** mthi 0xDEADBEEF while IDLE → visible in the next cycle. mtlo while `busy` → ignored, and the later commit overwrites LO.
- **reset:** reset asserted at cycle 3 of a div → `busy`=0, HI=LO=0 next cycle; no commit afterwards.
- **collisions:** `mdstart` and `hlwrite` in the same cycle → only the operation proceeds. `mdstart` during `busy` → ignored, original result committed on schedule.
